demux1to2_router: RTL

//   Stream-level 1-to-2 demultiplexer, the counterpart of the 2:1 data mux.

---
 rtl/demux_pkg.sv | 5 +
 rtl/demux_out_stage.sv | 39 +++
 rtl/demux1to2_router.sv | 86 ++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared types for the 1-to-2 stream demultiplexer: route-lock states and output count.
package demux_pkg;
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} route_state_t;
  localparam int NUM_OUT = 2;
endpackage

// File: rtl/demux_out_stage.sv
// One-entry valid/ready register slice; accepts a new beat in the same cycle it drains.
module demux_out_stage #(
  parameter int WIDTH = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fill,
  input  logic [WIDTH-1:0] fill_data,
  input  logic             fill_last,
  output logic             can_fill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);
  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic             last_p1;

  assign can_fill  = !vld_p1 || out_ready;
  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_last  = last_p1;

  // p1: output register, loaded only when the upstream handshake targets this slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (fill) begin
      vld_p1  <= 1'b1;
      data_p1 <= fill_data;
      last_p1 <= fill_last;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end
endmodule

// File: rtl/demux1to2_router.sv
// Packet-level 1-to-2 stream router: first beat picks the port, route locks until last beat.
module demux1to2_router
  import demux_pkg::*;
#(
  parameter int WIDTH = 100,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_last,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  route_state_t       state, state_nxt;
  logic               target;
  logic               accept;
  logic [NUM_OUT-1:0] fill;
  logic [NUM_OUT-1:0] can_fill;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    target = in_sel;
    case (state)
      LOCK0:   target = 1'b0;
      LOCK1:   target = 1'b1;
      default: target = in_sel;
    endcase
  end

  assign in_ready = can_fill[target];
  assign accept   = in_valid && in_ready;
  assign fill[0]  = accept && !target;
  assign fill[1]  = accept && target;

  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (in_last)     state_nxt = IDLE;
      else if (target) state_nxt = LOCK1;
      else             state_nxt = LOCK0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  demux_out_stage #(.WIDTH(WIDTH)) u_stage0 (
    .clk(clk), .rst_n(rst_n),
    .fill(fill[0]), .fill_data(in_data), .fill_last(in_last), .can_fill(can_fill[0]),
    .out_valid(out0_valid), .out_ready(out0_ready), .out_data(out0_data), .out_last(out0_last)
  );

  demux_out_stage #(.WIDTH(WIDTH)) u_stage1 (
    .clk(clk), .rst_n(rst_n),
    .fill(fill[1]), .fill_data(in_data), .fill_last(in_last), .can_fill(can_fill[1]),
    .out_valid(out1_valid), .out_ready(out1_ready), .out_data(out1_data), .out_last(out1_last)
  );

  // Delivered-beat counters stick at all-ones rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (out0_valid && out0_ready) cnt0 <= sat_inc(cnt0);
      if (out1_valid && out1_ready) cnt1 <= sat_inc(cnt1);
    end
  end
endmodule
